// File: rtl/baccarat_round_ctrl_if.sv
// rtl/baccarat_round_ctrl_if.sv - card request/valid handshake between round controller and card source
//
// Signals:
//   card_req   controller wants a card this cycle
//   card_slot  destination of the requested card (0=P1 1=D1 2=P2 3=D2 4=P3 5=D3)
//   card_valid card_rank carries a card this cycle
//   card_rank  card rank 1..13 (A..K)
// Modports:
//   master  round controller (issues requests, consumes cards)
//   slave   card source (answers requests)
interface baccarat_round_ctrl_if;
  logic       card_req;
  logic [2:0] card_slot;
  logic       card_valid;
  logic [3:0] card_rank;

  modport master (
    output card_req,
    output card_slot,
    input  card_valid,
    input  card_rank
  );

  modport slave (
    input  card_req,
    input  card_slot,
    output card_valid,
    output card_rank
  );
endinterface

// File: rtl/baccarat_round_ctrl.sv
// rtl/baccarat_round_ctrl.sv - punto-banco round sequencer with third-card tableau and saturating tallies
//
// Ports:
//   slow_clock        block clock, rising edge
//   resetb            synchronous active-low reset
//   start             begin a round (sampled in IDLE only)
//   card              handshake interface (master side): card_req/card_slot out, card_valid/card_rank in
//   pscore, dscore    player / banker hand scores 0..9
//   pcard3            value of player third card, 0 if none
//   natural           round ended on a natural
//   *_light           outcome of the last round (one-hot)
//   round_done        one-cycle pulse on entry to RESULT
//   bad_card          sticky, an out-of-range rank was offered
//   player_wins, dealer_wins, ties  saturating round tallies
module baccarat_round_ctrl #(
  parameter int CNT_W       = 8,
  parameter int HOLD_CYCLES = 4,
  parameter bit AUTO_START  = 1'b0
) (
  input  logic                  slow_clock,
  input  logic                  resetb,
  input  logic                  start,
  baccarat_round_ctrl_if.master card,
  output logic [3:0]            pscore,
  output logic [3:0]            dscore,
  output logic [3:0]            pcard3,
  output logic                  natural,
  output logic                  player_win_light,
  output logic                  dealer_win_light,
  output logic                  tie_light,
  output logic                  round_done,
  output logic                  bad_card,
  output logic [CNT_W-1:0]      player_wins,
  output logic [CNT_W-1:0]      dealer_wins,
  output logic [CNT_W-1:0]      ties
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_DP1, S_DD1, S_DP2, S_DD2, S_EVAL, S_DP3, S_DD3, S_RESULT
  } state_t;

  state_t              state;
  logic [HOLD_W-1:0]   hold_cnt;

  logic       rank_ok;
  logic       xfer;
  logic [3:0] card_val;
  logic [3:0] p_add;
  logic [3:0] d_add;
  logic       natural_hit;
  logic       banker_draw;
  logic       enter_result;
  logic       clear_round;
  logic [3:0] res_p;
  logic [3:0] res_d;

  function automatic logic [3:0] add_mod10(input logic [3:0] s, input logic [3:0] v);
    logic [4:0] t;
    t = {1'b0, s} + {1'b0, v};
    return (t >= 5'd10) ? 4'(t - 5'd10) : t[3:0];
  endfunction

  // Request decode straight from the state register.
  always_comb begin
    card.card_req  = 1'b0;
    card.card_slot = 3'd0;
    case (state)
      S_DP1: begin card.card_req = 1'b1; card.card_slot = 3'd0; end
      S_DD1: begin card.card_req = 1'b1; card.card_slot = 3'd1; end
      S_DP2: begin card.card_req = 1'b1; card.card_slot = 3'd2; end
      S_DD2: begin card.card_req = 1'b1; card.card_slot = 3'd3; end
      S_DP3: begin card.card_req = 1'b1; card.card_slot = 3'd4; end
      S_DD3: begin card.card_req = 1'b1; card.card_slot = 3'd5; end
      default: ;
    endcase
  end

  always_comb begin
    rank_ok     = (card.card_rank != 4'd0) && (card.card_rank <= 4'd13);
    xfer        = card.card_req & card.card_valid & rank_ok;
    card_val    = (card.card_rank <= 4'd9) ? card.card_rank : 4'd0;
    p_add       = add_mod10(pscore, card_val);
    d_add       = add_mod10(dscore, card_val);
    natural_hit = (pscore >= 4'd8) || (dscore >= 4'd8);

    // Banker tableau after the player drew; card_val is the player third card
    // being consumed on this edge, dscore still holds the two-card total.
    case (dscore)
      4'd0, 4'd1, 4'd2: banker_draw = 1'b1;
      4'd3:             banker_draw = (card_val != 4'd8);
      4'd4:             banker_draw = (card_val >= 4'd2) && (card_val <= 4'd7);
      4'd5:             banker_draw = (card_val >= 4'd4) && (card_val <= 4'd7);
      4'd6:             banker_draw = (card_val >= 4'd6) && (card_val <= 4'd7);
      default:          banker_draw = 1'b0;
    endcase

    // Final scores as they will stand after this edge, so the outcome lights
    // can be set on the same edge that enters RESULT.
    enter_result = 1'b0;
    res_p        = pscore;
    res_d        = dscore;
    case (state)
      S_EVAL: enter_result = natural_hit || ((pscore > 4'd5) && (dscore > 4'd5));
      S_DP3: if (xfer) begin
        res_p        = p_add;
        enter_result = !banker_draw;
      end
      S_DD3: if (xfer) begin
        res_d        = d_add;
        enter_result = 1'b1;
      end
      default: ;
    endcase

    clear_round = ((state == S_IDLE) && start) ||
                  ((state == S_RESULT) && (hold_cnt == '0) && AUTO_START);
  end

  always_ff @(posedge slow_clock) begin
    if (!resetb) begin
      state            <= S_IDLE;
      hold_cnt         <= '0;
      pscore           <= 4'd0;
      dscore           <= 4'd0;
      pcard3           <= 4'd0;
      natural          <= 1'b0;
      player_win_light <= 1'b0;
      dealer_win_light <= 1'b0;
      tie_light        <= 1'b0;
      round_done       <= 1'b0;
      bad_card         <= 1'b0;
      player_wins      <= '0;
      dealer_wins      <= '0;
      ties             <= '0;
    end else begin
      round_done <= 1'b0;
      if (card.card_req && card.card_valid && !rank_ok) bad_card <= 1'b1;

      case (state)
        S_IDLE: if (start) state <= S_DP1;
        S_DP1:  if (xfer) begin pscore <= p_add; state <= S_DD1; end
        S_DD1:  if (xfer) begin dscore <= d_add; state <= S_DP2; end
        S_DP2:  if (xfer) begin pscore <= p_add; state <= S_DD2; end
        S_DD2:  if (xfer) begin dscore <= d_add; state <= S_EVAL; end
        S_EVAL: begin
          if (natural_hit) begin
            natural <= 1'b1;
            state   <= S_RESULT;
          end else if (pscore <= 4'd5) begin
            state <= S_DP3;
          end else if (dscore <= 4'd5) begin
            state <= S_DD3;
          end else begin
            state <= S_RESULT;
          end
        end
        S_DP3: if (xfer) begin
          pscore <= p_add;
          pcard3 <= card_val;
          state  <= banker_draw ? S_DD3 : S_RESULT;
        end
        S_DD3: if (xfer) begin dscore <= d_add; state <= S_RESULT; end
        S_RESULT: begin
          if (hold_cnt == '0) state <= AUTO_START ? S_DP1 : S_IDLE;
          else                hold_cnt <= hold_cnt - HOLD_W'(1);
        end
        default: state <= S_IDLE;
      endcase

      if (enter_result) begin
        player_win_light <= (res_p > res_d);
        dealer_win_light <= (res_p < res_d);
        tie_light        <= (res_p == res_d);
        if ((res_p > res_d) && (player_wins != '1)) player_wins <= player_wins + CNT_W'(1);
        if ((res_p < res_d) && (dealer_wins != '1)) dealer_wins <= dealer_wins + CNT_W'(1);
        if ((res_p == res_d) && (ties != '1))       ties        <= ties + CNT_W'(1);
        round_done <= 1'b1;
        hold_cnt   <= HOLD_W'(HOLD_CYCLES - 1);
      end

      if (clear_round) begin
        pscore           <= 4'd0;
        dscore           <= 4'd0;
        pcard3           <= 4'd0;
        natural          <= 1'b0;
        player_win_light <= 1'b0;
        dealer_win_light <= 1'b0;
        tie_light        <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_baccarat_round_ctrl.sv
// tb/tb_baccarat_round_ctrl.sv - self-checking bench for baccarat_round_ctrl
module tb_baccarat_round_ctrl;

  localparam int HOLD   = 4;
  localparam int HOLD_A = 3;

  typedef struct packed {
    logic [2:0]      n;
    logic [5:0][2:0] slots;
    logic [3:0]      p;
    logic [3:0]      d;
    logic [3:0]      pc3;
    logic            nat;
    logic [2:0]      lights;   // {player, dealer, tie}
  } exp_t;

  typedef struct packed {
    logic [5:0][3:0] deck;
    logic [1:0]      stalls;
    exp_t            e;
  } vec_t;

  logic slow_clock = 1'b0;
  always #5 slow_clock = ~slow_clock;

  logic resetb, start, start_a;

  baccarat_round_ctrl_if ifm ();
  baccarat_round_ctrl_if ifa ();

  logic [3:0] pscore, dscore, pcard3;
  logic       natural, player_win_light, dealer_win_light, tie_light, round_done, bad_card;
  logic [7:0] player_wins, dealer_wins, ties;

  logic [3:0] pscore_a, dscore_a, pcard3_a;
  logic       natural_a, player_win_light_a, dealer_win_light_a, tie_light_a, round_done_a, bad_card_a;
  logic [1:0] player_wins_a, dealer_wins_a, ties_a;

  baccarat_round_ctrl #(.CNT_W(8), .HOLD_CYCLES(HOLD), .AUTO_START(1'b0)) dut (
    .slow_clock(slow_clock), .resetb(resetb), .start(start), .card(ifm),
    .pscore(pscore), .dscore(dscore), .pcard3(pcard3), .natural(natural),
    .player_win_light(player_win_light), .dealer_win_light(dealer_win_light),
    .tie_light(tie_light), .round_done(round_done), .bad_card(bad_card),
    .player_wins(player_wins), .dealer_wins(dealer_wins), .ties(ties)
  );

  baccarat_round_ctrl #(.CNT_W(2), .HOLD_CYCLES(HOLD_A), .AUTO_START(1'b1)) dut_a (
    .slow_clock(slow_clock), .resetb(resetb), .start(start_a), .card(ifa),
    .pscore(pscore_a), .dscore(dscore_a), .pcard3(pcard3_a), .natural(natural_a),
    .player_win_light(player_win_light_a), .dealer_win_light(dealer_win_light_a),
    .tie_light(tie_light_a), .round_done(round_done_a), .bad_card(bad_card_a),
    .player_wins(player_wins_a), .dealer_wins(dealer_wins_a), .ties(ties_a)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cur_round = 0;
  int ep = 0, ed = 0, et = 0;

  int xfer_mon = 0;
  int done_mon = 0;
  always @(posedge slow_clock) begin
    if (ifm.card_req && ifm.card_valid && ifm.card_rank >= 4'd1 && ifm.card_rank <= 4'd13) xfer_mon++;
    if (round_done) done_mon++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (round %0d): got %0h, expected %0h", name, cur_round, act, exp);
    end
  endtask

  function automatic logic [5:0][3:0] mk_deck(input int a, b, c, d, e, f);
    logic [5:0][3:0] k;
    k[0] = 4'(a); k[1] = 4'(b); k[2] = 4'(c);
    k[3] = 4'(d); k[4] = 4'(e); k[5] = 4'(f);
    return k;
  endfunction

  function automatic exp_t mk_exp(input int n, s0, s1, s2, s3, s4, s5,
                                  input int p, d, pc3, nat, input logic [2:0] lights);
    exp_t e;
    e.n = 3'(n);
    e.slots[0] = 3'(s0); e.slots[1] = 3'(s1); e.slots[2] = 3'(s2);
    e.slots[3] = 3'(s3); e.slots[4] = 3'(s4); e.slots[5] = 3'(s5);
    e.p = 4'(p); e.d = 4'(d); e.pc3 = 4'(pc3); e.nat = (nat != 0);
    e.lights = lights;
    return e;
  endfunction

  // Reference: deal a punto-banco round from a deck using the game rules.
  function automatic exp_t model(input logic [5:0][3:0] deck);
    exp_t e;
    int v[6];
    int p, d, k, t;
    bit draw;
    for (int i = 0; i < 6; i++) v[i] = (deck[i] <= 4'd9) ? int'(deck[i]) : 0;
    e = '0;
    e.slots = {6{3'd7}};
    for (int i = 0; i < 4; i++) e.slots[i] = 3'(i);
    p = (v[0] + v[2]) % 10;
    d = (v[1] + v[3]) % 10;
    k = 4;
    if (p >= 8 || d >= 8) begin
      e.nat = 1'b1;
    end else if (p <= 5) begin
      t = v[k]; e.slots[k] = 3'd4; k++;
      e.pc3 = 4'(t);
      p = (p + t) % 10;
      draw = (d <= 2) || (d == 3 && t != 8) || (d == 4 && t >= 2 && t <= 7) ||
             (d == 5 && t >= 4 && t <= 7) || (d == 6 && t >= 6 && t <= 7);
      if (draw) begin d = (d + v[k]) % 10; e.slots[k] = 3'd5; k++; end
    end else if (d <= 5) begin
      d = (d + v[k]) % 10; e.slots[k] = 3'd5; k++;
    end
    e.n = 3'(k); e.p = 4'(p); e.d = 4'(d);
    e.lights = (p > d) ? 3'b100 : (p < d) ? 3'b010 : 3'b001;
    return e;
  endfunction

  task automatic play_round(input logic [5:0][3:0] deck, input int stalls,
                            output int n, output logic [5:0][2:0] slots, output bit done);
    int st;
    n = 0; st = 0; done = 1'b0;
    slots = {6{3'd7}};
    start = 1'b1;
    @(negedge slow_clock);
    start = 1'b0;
    for (int it = 0; it < 400 && !done; it++) begin
      if (round_done) begin
        done = 1'b1;
      end else begin
        if (ifm.card_req && st < stalls) begin
          ifm.card_valid = 1'b0; st++;
        end else if (ifm.card_req && n < 6) begin
          ifm.card_valid = 1'b1; ifm.card_rank = deck[n];
          slots[n] = ifm.card_slot; n++; st = 0;
        end else begin
          ifm.card_valid = 1'b0;
        end
        @(negedge slow_clock);
      end
    end
    ifm.card_valid = 1'b0;
  endtask

  task automatic check_tallies();
    check("player_wins", player_wins, ep);
    check("dealer_wins", dealer_wins, ed);
    check("ties", ties, et);
  endtask

  task automatic run_check(input logic [5:0][3:0] deck, input int stalls, input exp_t e);
    int n, x0, d0;
    logic [5:0][2:0] slots;
    bit done;
    x0 = xfer_mon; d0 = done_mon;
    play_round(deck, stalls, n, slots, done);
    check("round_done_seen", done, 1);
    check("n_cards", n, e.n);
    check("slot_seq", slots, e.slots);
    check("pscore", pscore, e.p);
    check("dscore", dscore, e.d);
    check("pcard3", pcard3, e.pc3);
    check("natural", natural, e.nat);
    check("lights", {player_win_light, dealer_win_light, tie_light}, e.lights);
    check("transfers", xfer_mon - x0, e.n);
    check("req_in_result", ifm.card_req, 0);
    if (e.lights[2]) ep++;
    if (e.lights[1]) ed++;
    if (e.lights[0]) et++;
    check_tallies();
    repeat (HOLD + 1) @(negedge slow_clock);
    check("idle_no_req", ifm.card_req, 0);
    check("lights_held", {player_win_light, dealer_win_light, tie_light}, e.lights);
    check("done_pulses", done_mon - d0, 1);
    cur_round++;
  endtask

  task automatic offer_card(input logic [3:0] rank, input logic [2:0] slot);
    int k = 0;
    while (!ifm.card_req && k < 50) begin @(negedge slow_clock); k++; end
    check("offer_req", ifm.card_req, 1);
    check("offer_slot", ifm.card_slot, slot);
    ifm.card_valid = 1'b1; ifm.card_rank = rank;
    @(negedge slow_clock);
    ifm.card_valid = 1'b0;
  endtask

  task automatic wait_done();
    int k = 0;
    while (!round_done && k < 50) begin @(negedge slow_clock); k++; end
    check("wait_round_done", round_done, 1);
  endtask

  vec_t tbl[8];

  initial begin
    logic [5:0][3:0] deck;
    int k;
    int ar[4];

    tbl[0].deck = mk_deck(4, 2, 5, 3, 0, 0);  tbl[0].stalls = 0;
    tbl[0].e    = mk_exp(4, 0, 1, 2, 3, 7, 7, 9, 5, 0, 1, 3'b100);
    tbl[1].deck = mk_deck(2, 10, 3, 13, 7, 6); tbl[1].stalls = 0;
    tbl[1].e    = mk_exp(6, 0, 1, 2, 3, 4, 5, 2, 6, 7, 0, 3'b010);
    tbl[2].deck = mk_deck(3, 4, 3, 2, 0, 0);  tbl[2].stalls = 0;
    tbl[2].e    = mk_exp(4, 0, 1, 2, 3, 7, 7, 6, 6, 0, 0, 3'b001);
    tbl[3].deck = mk_deck(1, 2, 2, 1, 8, 9);  tbl[3].stalls = 0;
    tbl[3].e    = mk_exp(5, 0, 1, 2, 3, 4, 7, 1, 3, 8, 0, 3'b010);
    tbl[4].deck = mk_deck(7, 1, 10, 2, 5, 0); tbl[4].stalls = 0;
    tbl[4].e    = mk_exp(5, 0, 1, 2, 3, 5, 7, 7, 8, 0, 0, 3'b010);
    tbl[5].deck = mk_deck(1, 9, 1, 10, 0, 0); tbl[5].stalls = 0;
    tbl[5].e    = mk_exp(4, 0, 1, 2, 3, 7, 7, 2, 9, 0, 1, 3'b010);
    tbl[6].deck = mk_deck(2, 10, 3, 13, 7, 6); tbl[6].stalls = 3;
    tbl[6].e    = mk_exp(6, 0, 1, 2, 3, 4, 5, 2, 6, 7, 0, 3'b010);
    tbl[7].deck = mk_deck(6, 5, 2, 12, 3, 0); tbl[7].stalls = 0;
    tbl[7].e    = mk_exp(4, 0, 1, 2, 3, 7, 7, 8, 5, 0, 1, 3'b100);

    resetb = 1'b0; start = 1'b0; start_a = 1'b0;
    ifm.card_valid = 1'b0; ifm.card_rank = 4'd0;
    ifa.card_valid = 1'b0; ifa.card_rank = 4'd0;
    repeat (3) @(negedge slow_clock);
    check("rst_req", ifm.card_req, 0);
    check("rst_slot", ifm.card_slot, 0);
    check("rst_scores", {pscore, dscore, pcard3}, 0);
    check("rst_flags", {natural, player_win_light, dealer_win_light, tie_light, round_done, bad_card}, 0);
    check("rst_tallies", {player_wins, dealer_wins, ties}, 0);
    check("rst_a", {ifa.card_req, player_wins_a, round_done_a}, 0);
    resetb = 1'b1;
    @(negedge slow_clock);

    foreach (tbl[i]) run_check(tbl[i].deck, int'(tbl[i].stalls), tbl[i].e);

    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < 6; i++) deck[i] = 4'($urandom_range(1, 13));
      run_check(deck, int'($urandom_range(0, 2)), model(deck));
    end

    // Offers while idle are ignored, even out-of-range ones.
    ifm.card_valid = 1'b1; ifm.card_rank = 4'd14;
    repeat (2) @(negedge slow_clock);
    ifm.card_valid = 1'b0;
    check("idle_ignore_bad", bad_card, 0);
    check("idle_ignore_req", ifm.card_req, 0);

    // Bad rank in DD1 holds the state and sets the sticky flag.
    start = 1'b1; @(negedge slow_clock); start = 1'b0;
    offer_card(4'd5, 3'd0);
    ifm.card_valid = 1'b1; ifm.card_rank = 4'd14;
    @(negedge slow_clock);
    ifm.card_valid = 1'b0;
    check("bad_hold_req", ifm.card_req, 1);
    check("bad_hold_slot", ifm.card_slot, 1);
    check("bad_card_set", bad_card, 1);
    check("bad_scores", {pscore, dscore}, {4'd5, 4'd0});
    offer_card(4'd3, 3'd1);
    offer_card(4'd1, 3'd2);
    offer_card(4'd1, 3'd3);
    offer_card(4'd3, 3'd5);
    wait_done();
    check("bad_round_scores", {pscore, dscore}, {4'd6, 4'd7});
    check("bad_round_lights", {player_win_light, dealer_win_light, tie_light}, 3'b010);
    check("bad_card_sticky", bad_card, 1);
    ed++;
    check_tallies();
    repeat (HOLD + 1) @(negedge slow_clock);
    cur_round++;

    // Reset while waiting for the player third card.
    start = 1'b1; @(negedge slow_clock); start = 1'b0;
    offer_card(4'd1, 3'd0);
    offer_card(4'd2, 3'd1);
    offer_card(4'd2, 3'd2);
    offer_card(4'd1, 3'd3);
    k = 0;
    while (!ifm.card_req && k < 20) begin @(negedge slow_clock); k++; end
    check("dp3_slot", ifm.card_slot, 4);
    resetb = 1'b0;
    @(negedge slow_clock);
    check("mid_rst_req", ifm.card_req, 0);
    check("mid_rst_scores", {pscore, dscore, pcard3}, 0);
    check("mid_rst_flags", {natural, player_win_light, dealer_win_light, tie_light, round_done, bad_card}, 0);
    check("mid_rst_tallies", {player_wins, dealer_wins, ties}, 0);
    resetb = 1'b1;
    ep = 0; ed = 0; et = 0;
    @(negedge slow_clock);
    run_check(tbl[0].deck, 0, tbl[0].e);

    // Auto-restart instance: five player naturals, tally saturates at 3.
    ar[0] = 4; ar[1] = 2; ar[2] = 5; ar[3] = 3;
    start_a = 1'b1; @(negedge slow_clock); start_a = 1'b0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 4; c++) begin
        k = 0;
        while (!ifa.card_req && k < 20) begin @(negedge slow_clock); k++; end
        check("auto_req", ifa.card_req, 1);
        ifa.card_valid = 1'b1; ifa.card_rank = 4'(ar[c]);
        @(negedge slow_clock);
        ifa.card_valid = 1'b0;
      end
      k = 0;
      while (!round_done_a && k < 20) begin @(negedge slow_clock); k++; end
      check("auto_done", round_done_a, 1);
      check("auto_scores", {pscore_a, dscore_a, 3'b000, natural_a}, {4'd9, 4'd5, 4'd1});
      check("auto_light", player_win_light_a, 1);
      check("auto_wins", player_wins_a, (r + 1 > 3) ? 3 : r + 1);
      k = 0;
      while (!ifa.card_req && k < 20) begin @(negedge slow_clock); k++; end
      check("auto_hold", k, HOLD_A);
      check("auto_slot0", ifa.card_slot, 0);
      check("auto_cleared", {pscore_a, player_win_light_a}, 0);
      cur_round++;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
